// File: rtl/controle_multiciclo_if.sv
// Control bundle between the multicycle controller and the datapath.
// Instruction fields and zero flag in, muxes/enables/ALU code out.
interface controle_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [1:0] pc_src;
  logic [3:0] ula_op;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_write, ir_write,
    output reg_write, reg_dst, mem_to_reg,
    output alu_src_a, alu_src_b, ext_zero,
    output pc_src, ula_op, illegal, state
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_write, ir_write,
    input  reg_write, reg_dst, mem_to_reg,
    input  alu_src_a, alu_src_b, ext_zero,
    input  pc_src, ula_op, illegal, state
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset control FSM.
// Moore decode of state/opcode/funct; BRANCH pc_en also uses zero.
module controle_multiciclo (
  input  logic clock,
  input  logic reset_n,
  controle_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_SRL = 4'b1111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q;
  state_t state_d;
  // active stays low through reset and the cycle after release,
  // so every output is 0 until the first FETCH edge.
  logic   active;

  logic       r_ok;
  logic       r_shift;
  logic [3:0] r_op;
  logic       dec_ill;

  // R-type funct to ALU code, legality and shift detection
  always_comb begin
    r_ok    = 1'b1;
    r_shift = 1'b0;
    r_op    = ALU_ADD;
    case (bus.funct)
      6'h20: r_op = ALU_ADD;
      6'h22: r_op = ALU_SUB;
      6'h24: r_op = ALU_AND;
      6'h25: r_op = ALU_OR;
      6'h26: r_op = ALU_XOR;
      6'h27: r_op = ALU_NOR;
      6'h2A: r_op = ALU_SLT;
      6'h00: begin
        r_op    = ALU_SLL;
        r_shift = 1'b1;
      end
      6'h02: begin
        r_op    = ALU_SRL;
        r_shift = 1'b1;
      end
      default: r_ok = 1'b0;
    endcase
  end

  // next-state logic; illegal instructions fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    dec_ill = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:
            state_d = S_MEMADR;
          OP_R: begin
            if (r_ok) state_d = S_RTYPE;
            else      dec_ill = 1'b1;
          end
          OP_BEQ, OP_BNE:
            state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:
            state_d = S_IMMEX;
          OP_J:
            state_d = S_JUMP;
          default:
            dec_ill = 1'b1;
        endcase
      end
      S_MEMADR:
        state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: state_d = S_MEMWB;
      S_RTYPE: state_d = S_ALUWB;
      S_IMMEX: state_d = S_IMMWB;
      default: state_d = S_FETCH;
    endcase
  end

  // state register; first edge after reset only arms the FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      active  <= 1'b0;
    end else if (!active) begin
      state_q <= S_FETCH;
      active  <= 1'b1;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode, forced to 0 while not active
  always_comb begin
    bus.pc_en      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 2'd0;
    bus.alu_src_b  = 2'd0;
    bus.ext_zero   = 1'b0;
    bus.pc_src     = 2'd0;
    bus.ula_op     = 4'b0000;
    bus.illegal    = 1'b0;
    bus.state      = 4'd0;
    if (active) begin
      bus.state  = state_q;
      bus.ula_op = ALU_ADD;
      case (state_q)
        S_FETCH: begin
          bus.ir_write  = 1'b1;
          bus.pc_en     = 1'b1;
          bus.alu_src_b = 2'd1;
        end
        S_DECODE: begin
          bus.alu_src_b = 2'd3;
          bus.illegal   = dec_ill;
        end
        S_MEMADR: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd2;
        end
        S_MEMRD: bus.iord = 1'b1;
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          bus.iord      = 1'b1;
          bus.mem_write = 1'b1;
        end
        S_RTYPE: begin
          bus.alu_src_a = r_shift ? 2'd2 : 2'd1;
          bus.ula_op    = r_op;
        end
        S_ALUWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 2'd1;
          bus.ula_op    = ALU_SUB;
          bus.pc_src    = 2'd1;
          bus.pc_en     = (bus.opcode == OP_BNE) ?
                          !bus.zero : bus.zero;
        end
        S_IMMEX: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd2;
          case (bus.opcode)
            OP_ANDI: begin
              bus.ula_op   = ALU_AND;
              bus.ext_zero = 1'b1;
            end
            OP_ORI: begin
              bus.ula_op   = ALU_OR;
              bus.ext_zero = 1'b1;
            end
            default: bus.ula_op = ALU_ADD;
          endcase
        end
        S_IMMWB: bus.reg_write = 1'b1;
        S_JUMP: begin
          bus.pc_en  = 1'b1;
          bus.pc_src = 2'd2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control unit for the 32-bit MIPS-subset datapath. It sequences fetch, decode, execute, memory and writeback for one instruction at a time. It issues the 4-bit ALU operation code consumed by the `ula` block and reads back that block's zero flag to resolve conditional branches. It sits between the instruction register and every datapath mux and enable.

## Interface
Parameters: none; opcode, funct and ALU codes are fixed by this document.

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]; stable from the edge ending FETCH until the next FETCH
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, combinational from `ula`
- `pc_en`  out  1  PC load enable
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  data memory write
- `ir_write`  out  1  IR load
- `reg_write`  out  1  register file write
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = MDR
- `alu_src_a`  out  2  ALU In1 select: 0 = PC, 1 = A, 2 = zero-extended shamt
- `alu_src_b`  out  2  ALU In2 select: 0 = B, 1 = 4, 2 = ext imm, 3 = ext imm<<2
- `ext_zero`  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- `pc_src`  out  2  PC next select: 0 = ALU result, 1 = ALUOut, 2 = jump target
- `ula_op`  out  4  ALU operation code
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct
- `state`  out  4  current state, for debug

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, XOR 1101, SLL 1110, SRL 1111.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- R funct to ALU code: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL.
- Shift operands: the ALU shifts In2 by In1. For SLL/SRL, RTYPE_EX drives `alu_src_a`=2 (shamt) and `alu_src_b`=0 (B). All other R ops use `alu_src_a`=1.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, ALUWB 7, BRANCH 8, IMM_EX 9, IMMWB 10, JUMP 11. Codes 12–15 are unused and return to FETCH.
- Outputs are Moore-decoded from `state`, `opcode` and `funct`. The one exception is `pc_en` in BRANCH, which also depends on `zero`. Every output not listed for a state is 0.
- FETCH: `ir_write`=1, `pc_en`=1, `alu_src_a`=0, `alu_src_b`=1, ADD, `pc_src`=0, `iord`=0. Next: DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, ADD (precomputes the branch target into ALUOut). Next state by opcode:
  - lw/sw → MEMADR
  - R with a legal funct → RTYPE_EX
  - beq/bne → BRANCH
  - addi/andi/ori → IMM_EX
  - j → JUMP
  - anything else → FETCH with `illegal`=1
- MEMADR: `alu_src_a`=1, `alu_src_b`=2, ADD. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1. Next: MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next: FETCH.
- MEMWR: `iord`=1, `mem_write`=1. Next: FETCH.
- RTYPE_EX: `alu_src_b`=0, `ula_op` from funct. Next: ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1. Next: FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_src`=1. `pc_en`=`zero` for beq, `pc_en`=!`zero` for bne. Next: FETCH.
- IMM_EX: `alu_src_a`=1, `alu_src_b`=2. addi: ADD with `ext_zero`=0. andi: AND with `ext_zero`=1. ori: OR with `ext_zero`=1. Next: IMMWB.
- IMMWB: `reg_write`=1, `reg_dst`=0. Next: FETCH.
- JUMP: `pc_en`=1, `pc_src`=2. Next: FETCH.
- In states that do not use the ALU, `ula_op` = ADD (0010).

## Timing
- `reset_n` low immediately forces state = FETCH and all outputs to 0. `ula_op` reads 0000 during reset.
- The first FETCH takes effect on the first rising edge after `reset_n` deasserts.
- Asserting reset mid-instruction abandons the instruction. No write occurs after reset assertion.
- Cycles per instruction: lw 5; sw, R, addi/andi/ori 4; beq, bne, j 3; illegal 2.
- `illegal` is high only during the DECODE cycle of the offending instruction.
- `zero` is sampled combinationally in BRANCH only. A glitch in `zero` in any other state has no effect.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles, then release → all outputs 0 during reset. `state` reads 0, 1, … on the following edges. `ir_write`=1 in the first cycle.
- lw (opcode 100011) → state sequence 0, 1, 2, 3, 4, 0. MEMRD has `iord`=1. MEMWB has `reg_write`=1 and `mem_to_reg`=1.
- R-type, each legal funct → correct `ula_op`; for example funct 0x2A gives 0111. funct 0x00 gives 1110 with `alu_src_a`=2. ALUWB has `reg_dst`=1.
- beq with `zero`=1, then with `zero`=0 → `pc_en`=1 and `pc_en`=0 respectively in state 8. bne gives the inverse. Each takes 3 cycles.
- Illegal opcode 111111, then R with funct 0x3F → `illegal` pulses once per instruction. The next state is FETCH. `reg_write` and `mem_write` stay 0.
- Reset asserted during MEMWR → `mem_write` drops the same cycle. After release, the sequence restarts at FETCH.
